// File: rtl/cpu_pkg.sv
// Shared types and bit positions for the Hack CPU execution sequencer.
// States, decoded C-instruction layout and the jump-condition helper.
package cpu_pkg;

  localparam int D_W = 16;

  localparam int CI_BIT   = 15;
  localparam int A_BIT    = 12;
  localparam int COMP_MSB = 11;
  localparam int COMP_LSB = 6;
  localparam int DEST_MSB = 5;
  localparam int DEST_LSB = 3;
  localparam int JMP_MSB  = 2;
  localparam int JMP_LSB  = 0;

  // Indices inside the decoded dest/jmp/comp fields
  localparam int DEST_A = 2;
  localparam int DEST_D = 1;
  localparam int DEST_M = 0;
  localparam int JMP_LT = 2;
  localparam int JMP_EQ = 1;
  localparam int JMP_GT = 0;
  localparam int COMP_F = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_t;

  typedef struct packed {
    logic       a;
    logic [5:0] comp;
    logic [2:0] dest;
    logic [2:0] jmp;
  } cinst_t;

  function automatic logic jump_taken(input logic [2:0] jmp, input logic zr, input logic ng);
    return (jmp[JMP_LT] & ng) | (jmp[JMP_EQ] & zr) | (jmp[JMP_GT] & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/cpu_exec_if.sv
// Bundle of the instruction, ALU, memory-write and branch-report channels.
// slave = view of cpu_exec; master = view of the surrounding system.
interface cpu_exec_if;
  import cpu_pkg::*;

  logic           vld_s, rdy_s;
  logic [D_W-1:0] inst_s, m_s;
  logic           alu_vld_m, alu_rdy_m;
  logic [D_W-1:0] alu_x_m, alu_y_m;
  logic           alu_zx_m, alu_nx_m, alu_zy_m, alu_ny_m, alu_f_m, alu_no_m;
  logic           alu_vld_s, alu_rdy_s;
  logic [D_W-1:0] alu_out_s;
  logic           alu_zr_s, alu_ng_s, alu_of_s;
  logic           wr_vld_m, wr_rdy_m;
  logic [D_W-1:0] wr_addr_m, wr_data_m;
  logic           br_vld_m, br_taken_m;
  logic [D_W-1:0] br_addr_m;
  logic [D_W-1:0] a_m, d_m;
  logic           ovf_m;

  modport slave (
    input  vld_s, inst_s, m_s, alu_rdy_m, alu_vld_s, alu_out_s,
           alu_zr_s, alu_ng_s, alu_of_s, wr_rdy_m,
    output rdy_s, alu_vld_m, alu_x_m, alu_y_m, alu_zx_m, alu_nx_m,
           alu_zy_m, alu_ny_m, alu_f_m, alu_no_m, alu_rdy_s,
           wr_vld_m, wr_addr_m, wr_data_m, br_vld_m, br_taken_m,
           br_addr_m, a_m, d_m, ovf_m
  );

  modport master (
    output vld_s, inst_s, m_s, alu_rdy_m, alu_vld_s, alu_out_s,
           alu_zr_s, alu_ng_s, alu_of_s, wr_rdy_m,
    input  rdy_s, alu_vld_m, alu_x_m, alu_y_m, alu_zx_m, alu_nx_m,
           alu_zy_m, alu_ny_m, alu_f_m, alu_no_m, alu_rdy_s,
           wr_vld_m, wr_addr_m, wr_data_m, br_vld_m, br_taken_m,
           br_addr_m, a_m, d_m, ovf_m
  );

endinterface

// File: rtl/hack_inst_dec.sv
// Combinational Hack instruction decoder; bits 14:13 of a C-instruction
// carry no meaning and are dropped.
module hack_inst_dec
  import cpu_pkg::*;
(
  input  logic [D_W-1:0] i_inst,
  output logic           o_is_c,
  output cinst_t         o_dec
);

  assign o_is_c     = i_inst[CI_BIT];
  assign o_dec.a    = i_inst[A_BIT];
  assign o_dec.comp = i_inst[COMP_MSB:COMP_LSB];
  assign o_dec.dest = i_inst[DEST_MSB:DEST_LSB];
  assign o_dec.jmp  = i_inst[JMP_MSB:JMP_LSB];

endmodule

// File: rtl/cpu_exec.sv
// Hack CPU execution sequencer: holds A/D, issues one ALU op per C-instruction,
// writes back, drives dest-M writes and reports jumps. Optional: ALU_OF_TRAP_EN.
//
// state | meaning
// IDLE  | accept instructions; A-instructions complete here
// ISSUE | operands offered to the ALU; a same-cycle result is taken directly
// WAIT  | operands taken, waiting for the ALU result
// WRITE | memory write of the result to addr_q pending
module cpu_exec
  import cpu_pkg::*;
(
  input logic      clk,
  input logic      rstn,
  cpu_exec_if.slave bus
);

  state_t         r_state, w_state_nxt, w_wb_nxt;
  cinst_t         w_dec, r_dec;
  logic           w_is_c;
  logic [D_W-1:0] r_a, r_d, r_x, r_y, r_addr, r_wdata, r_br_addr;
  logic           r_br_vld, r_br_taken, r_live;
  logic           w_acc, w_res_fire, w_trap;

  hack_inst_dec u_dec (
    .i_inst (bus.inst_s),
    .o_is_c (w_is_c),
    .o_dec  (w_dec)
  );

  assign w_acc      = bus.rdy_s && bus.vld_s;
  assign w_res_fire = bus.alu_vld_s && ((r_state == ISSUE) || (r_state == WAIT));

`ifdef ALU_OF_TRAP_EN
  logic r_ovf;
  logic w_of_hit;

  // The trapping instruction itself is already suppressed
  assign w_of_hit = bus.alu_of_s & r_dec.comp[COMP_F];
  assign w_trap   = r_ovf | w_of_hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                       r_ovf <= 1'b0;
    else if (w_res_fire && w_of_hit) r_ovf <= 1'b1;
  end

  assign bus.ovf_m = r_ovf;
`else
  assign w_trap    = 1'b0;
  assign bus.ovf_m = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_wb_nxt    = (r_dec.dest[DEST_M] && !w_trap) ? WRITE : IDLE;
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_acc && w_is_c) w_state_nxt = ISSUE;
      ISSUE: begin
        if (bus.alu_vld_s)      w_state_nxt = w_wb_nxt;
        else if (bus.alu_rdy_m) w_state_nxt = WAIT;
      end
      WAIT:    if (bus.alu_vld_s) w_state_nxt = w_wb_nxt;
      WRITE:   if (bus.wr_rdy_m)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Keeps rdy_s low while in reset and for the first cycle after it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_live <= 1'b0;
    else       r_live <= 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a        <= '0;
      r_d        <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_br_addr  <= '0;
      r_br_vld   <= 1'b0;
      r_br_taken <= 1'b0;
      r_dec      <= '0;
    end else begin
      r_br_vld <= 1'b0;
      if (w_acc) begin
        if (!w_is_c) begin
          r_a <= bus.inst_s;
        end else begin
          r_dec  <= w_dec;
          r_x    <= r_d;
          r_y    <= w_dec.a ? bus.m_s : r_a;
          r_addr <= r_a;
        end
      end
      if (w_res_fire) begin
        if (r_dec.dest[DEST_A] && !w_trap) r_a <= bus.alu_out_s;
        if (r_dec.dest[DEST_D] && !w_trap) r_d <= bus.alu_out_s;
        r_wdata    <= bus.alu_out_s;
        r_br_vld   <= 1'b1;
        r_br_addr  <= r_addr;
        r_br_taken <= !w_trap && jump_taken(r_dec.jmp, bus.alu_zr_s, bus.alu_ng_s);
      end
    end
  end

  assign bus.rdy_s      = (r_state == IDLE) && r_live;
  assign bus.alu_vld_m  = (r_state == ISSUE);
  assign bus.alu_rdy_s  = (r_state == ISSUE) || (r_state == WAIT);
  assign bus.wr_vld_m   = (r_state == WRITE);
  assign bus.alu_x_m    = r_x;
  assign bus.alu_y_m    = r_y;
  assign {bus.alu_zx_m, bus.alu_nx_m, bus.alu_zy_m,
          bus.alu_ny_m, bus.alu_f_m,  bus.alu_no_m} = r_dec.comp;
  assign bus.wr_addr_m  = r_addr;
  assign bus.wr_data_m  = r_wdata;
  assign bus.br_vld_m   = r_br_vld;
  assign bus.br_taken_m = r_br_taken;
  assign bus.br_addr_m  = r_br_addr;
  assign bus.a_m        = r_a;
  assign bus.d_m        = r_d;

endmodule

// File: tb/tb_cpu_exec.sv
// Self-checking bench for cpu_exec: directed cases plus random instruction mix
// against an instruction-level model of the Hack A/D/M semantics.
module tb_cpu_exec;
  import cpu_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  cpu_exec_if bus ();

  cpu_exec u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] m_a, m_d;
  logic        m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hack ALU as defined by the instruction set
  function automatic logic [15:0] ref_alu(input logic [15:0] x, input logic [15:0] y,
                                          input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'd0 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'd0 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? 16'(xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.vld_s     = 1'b0;
    bus.inst_s    = '0;
    bus.m_s       = '0;
    bus.alu_rdy_m = 1'b0;
    bus.alu_vld_s = 1'b0;
    bus.alu_out_s = '0;
    bus.alu_zr_s  = 1'b0;
    bus.alu_ng_s  = 1'b0;
    bus.alu_of_s  = 1'b0;
    bus.wr_rdy_m  = 1'b0;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_rdy_s"},     bus.rdy_s,      0);
    chk({p, "_alu_vld"},   bus.alu_vld_m,  0);
    chk({p, "_alu_rdy_s"}, bus.alu_rdy_s,  0);
    chk({p, "_wr_vld"},    bus.wr_vld_m,   0);
    chk({p, "_br_vld"},    bus.br_vld_m,   0);
    chk({p, "_br_taken"},  bus.br_taken_m, 0);
    chk({p, "_br_addr"},   bus.br_addr_m,  0);
    chk({p, "_a"},         bus.a_m,        0);
    chk({p, "_d"},         bus.d_m,        0);
    chk({p, "_ovf"},       bus.ovf_m,      0);
    chk({p, "_x"},         bus.alu_x_m,    0);
    chk({p, "_y"},         bus.alu_y_m,    0);
    chk({p, "_wr_addr"},   bus.wr_addr_m,  0);
    chk({p, "_wr_data"},   bus.wr_data_m,  0);
  endtask

  task automatic do_a(input logic [15:0] v);
    chk("a_rdy", bus.rdy_s, 1);
    bus.vld_s  = 1'b1;
    bus.inst_s = v;
    bus.m_s    = 16'($urandom);
    tick();
    bus.vld_s = 1'b0;
    m_a = v;
    chk("a_reg",   bus.a_m,       m_a);
    chk("a_noalu", bus.alu_vld_m, 0);
    chk("a_nobr",  bus.br_vld_m,  0);
  endtask

  task automatic put_res(input logic [15:0] o, input bit of);
    bus.alu_vld_s = 1'b1;
    bus.alu_out_s = o;
    bus.alu_zr_s  = (o == 16'd0);
    bus.alu_ng_s  = o[15];
    bus.alu_of_s  = of;
  endtask

  task automatic do_c(input logic [15:0] ins, input logic [15:0] m, input int idly,
                      input bit comb, input int rdly, input int wdly, input bit of);
    logic [15:0] x, y, o, addr;
    logic [5:0]  c;
    bit          trap, tk, wm;
    c    = ins[11:6];
    x    = m_d;
    y    = ins[12] ? m : m_a;
    addr = m_a;
    o    = ref_alu(x, y, c);

    chk("c_rdy", bus.rdy_s, 1);
    bus.vld_s  = 1'b1;
    bus.inst_s = ins;
    bus.m_s    = m;
    tick();
    bus.vld_s  = 1'b0;
    bus.inst_s = 16'($urandom);
    bus.m_s    = 16'($urandom);

    for (int i = 0; i <= idly; i++) begin
      chk("iss_vld", bus.alu_vld_m, 1);
      chk("iss_x",   bus.alu_x_m,   x);
      chk("iss_y",   bus.alu_y_m,   y);
      chk("iss_ctl", {bus.alu_zx_m, bus.alu_nx_m, bus.alu_zy_m,
                      bus.alu_ny_m, bus.alu_f_m,  bus.alu_no_m}, c);
      chk("iss_rdy_s", bus.rdy_s, 0);
      if (i == idly) begin
        bus.alu_rdy_m = 1'b1;
        if (comb) put_res(o, of);
      end
      tick();
    end
    bus.alu_rdy_m = 1'b0;

    if (!comb) begin
      bus.alu_vld_s = 1'b0;
      for (int i = 0; i < rdly; i++) begin
        chk("wait_novld", bus.alu_vld_m, 0);
        chk("wait_nobr",  bus.br_vld_m,  0);
        tick();
      end
      put_res(o, of);
      tick();
    end
    bus.alu_vld_s = 1'b0;
    bus.alu_of_s  = 1'b0;

    trap = 1'b0;
`ifdef ALU_OF_TRAP_EN
    if (of && c[1]) m_ovf = 1'b1;
    trap = m_ovf;
`endif
    tk = !trap && ((ins[2] && $signed(o) < 0) || (ins[1] && o == 16'd0) ||
                   (ins[0] && $signed(o) > 0));
    if (!trap) begin
      if (ins[5]) m_a = o;
      if (ins[4]) m_d = o;
    end
    wm = ins[3] && !trap;

    chk("wb_br_vld",   bus.br_vld_m,   1);
    chk("wb_br_taken", bus.br_taken_m, tk);
    chk("wb_br_addr",  bus.br_addr_m,  addr);
    chk("wb_a",        bus.a_m,        m_a);
    chk("wb_d",        bus.d_m,        m_d);
    chk("wb_ovf",      bus.ovf_m,      m_ovf);

    if (wm) begin
      for (int i = 0; i <= wdly; i++) begin
        chk("wr_vld",   bus.wr_vld_m,  1);
        chk("wr_addr",  bus.wr_addr_m, addr);
        chk("wr_data",  bus.wr_data_m, o);
        chk("wr_rdy_s", bus.rdy_s,     0);
        if (i == wdly) bus.wr_rdy_m = 1'b1;
        tick();
      end
      bus.wr_rdy_m = 1'b0;
      chk("wr_done", bus.wr_vld_m, 0);
      chk("wr_rdy_back", bus.rdy_s, 1);
      chk("wr_br_pulse", bus.br_vld_m, 0);
    end else begin
      chk("c_lat_rdy", bus.rdy_s,    1);
      chk("c_no_wr",   bus.wr_vld_m, 0);
      tick();
      chk("c_br_pulse", bus.br_vld_m, 0);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    drive_idle();
    m_a = '0; m_d = '0; m_ovf = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rstn = 1'b1;
    tick();
    tick();

    do_a(16'h0005);
    do_c(16'hEC10, 16'h1234, 0, 1, 0, 0, 0);
    do_a(16'd100);
    do_c(16'hE7C8, 16'h0000, 0, 1, 0, 3, 0);
    do_a(16'h0000);
    do_c(16'hEA90, 16'h0000, 0, 0, 0, 0, 0);
    do_a(16'd42);
    do_c(16'hE302, 16'h0000, 0, 0, 1, 0, 0);
    do_c(16'hEA87, 16'h0000, 0, 1, 0, 0, 0);
    do_a(16'd7);
    do_c(16'hF7D8, 16'h0102, 4, 1, 0, 1, 0);

    // abandon an instruction sitting in WAIT
    bus.vld_s  = 1'b1;
    bus.inst_s = 16'hEC18;
    tick();
    bus.vld_s     = 1'b0;
    bus.alu_rdy_m = 1'b1;
    tick();
    bus.alu_rdy_m = 1'b0;
    chk("wait_state", bus.alu_rdy_s, 1);
    rstn = 1'b0;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    rstn = 1'b1;
    m_a = '0; m_d = '0; m_ovf = 1'b0;
    tick();
    chk("midrst_nowr", bus.wr_vld_m, 0);
    tick();
    chk("midrst_nobr", bus.br_vld_m, 0);
    do_a(16'd3);
    do_c(16'hEC10, 16'h0000, 0, 1, 0, 0, 0);

    for (int k = 0; k < 60; k++) begin
      r = $urandom;
      if (r[1:0] == 2'd0) begin
        do_a({1'b0, r[30:16]});
      end else begin
        do_c({3'b111, r[28:16]}, 16'($urandom), int'($urandom_range(0, 2)),
             bit'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0));
      end
    end

`ifdef ALU_OF_TRAP_EN
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    m_a = '0; m_d = '0; m_ovf = 1'b0;
    tick();
    tick();
    do_a(16'h7FFF);
    do_c(16'hEC10, 16'h0000, 0, 1, 0, 0, 0);
    do_c(16'hE7D2, 16'h0000, 0, 1, 0, 0, 1);
    chk("trap_ovf", bus.ovf_m, 1);
    chk("trap_d",   bus.d_m,   16'h7FFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
